// File: rtl/sar_search_4bit.sv
// Successive-approximation search controller: drives the comparator B operand and bisects on its flags.
// Optional macro SAR_SEARCH_ERR_EN: a non-one-hot flag set aborts the search and raises err.
module sar_search_4bit #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         AeqB,
   input  logic         AgtB,
   input  logic         AltB,
   output logic [W-1:0] probe,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] result,
   output logic         found,
   output logic         err
);

   typedef enum logic [1:0] {IDLE, PROBE, DONE} stateT;

   stateT        state, stateNext;
   logic [W-1:0] lo, hi;
   logic [W-1:0] loNext, hiNext, probeNext, resultNext;
   logic         foundNext;
   logic         isEq, isGt, isBad;

   // Sum is one bit wider than the operands; the shift drops the LSB and keeps W bits.
   function automatic logic [W-1:0] midpoint(input logic [W:0] sum);
      return sum[W:1];
   endfunction

`ifdef SAR_SEARCH_ERR_EN
   logic errNext;

   always_comb begin
      isBad = !$onehot({AeqB, AgtB, AltB});
      isEq  = AeqB;
      isGt  = AgtB;
   end
`else
   logic unusedAltB;

   // AltB is implied by the fall-through, so all-zero flags also narrow downwards.
   assign unusedAltB = AltB;
   assign isBad      = 1'b0;
   assign isEq       = AeqB;
   assign isGt       = !AeqB && AgtB;
   assign err        = 1'b0;
`endif

   assign busy = (state == PROBE);
   assign done = (state == DONE);

   always_comb begin
      stateNext  = state;
      loNext     = lo;
      hiNext     = hi;
      probeNext  = probe;
      resultNext = result;
      foundNext  = found;
`ifdef SAR_SEARCH_ERR_EN
      errNext    = err;
`endif
      unique case (state)
         IDLE: begin
            if (start) begin
               stateNext = PROBE;
               loNext    = '0;
               hiNext    = '1;
               probeNext = {1'b0, {(W-1){1'b1}}};
               foundNext = 1'b0;
`ifdef SAR_SEARCH_ERR_EN
               errNext   = 1'b0;
`endif
            end
         end
         PROBE: begin
            if (isBad) begin
               resultNext = probe;
               foundNext  = 1'b0;
               stateNext  = DONE;
`ifdef SAR_SEARCH_ERR_EN
               errNext    = 1'b1;
`endif
            end else if (isEq) begin
               resultNext = probe;
               foundNext  = 1'b1;
               stateNext  = DONE;
            end else if (isGt) begin
               // probe==hi means the interval is exhausted; stepping lo past it would wrap.
               if (probe == hi) begin
                  resultNext = probe;
                  foundNext  = 1'b0;
                  stateNext  = DONE;
               end else begin
                  loNext    = probe + W'(1);
                  probeNext = midpoint({1'b0, probe} + {1'b0, hi} + (W+1)'(1));
               end
            end else begin
               if (probe == lo) begin
                  resultNext = probe;
                  foundNext  = 1'b0;
                  stateNext  = DONE;
               end else begin
                  hiNext    = probe - W'(1);
                  probeNext = midpoint({1'b0, lo} + {1'b0, probe} - (W+1)'(1));
               end
            end
         end
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         lo     <= '0;
         hi     <= '1;
         probe  <= '0;
         result <= '0;
         found  <= 1'b0;
      end else begin
         state  <= stateNext;
         lo     <= loNext;
         hi     <= hiNext;
         probe  <= probeNext;
         result <= resultNext;
         found  <= foundNext;
      end
   end

`ifdef SAR_SEARCH_ERR_EN
   always_ff @(posedge clk) begin
      if (rst) err <= 1'b0;
      else     err <= errNext;
   end
`endif

endmodule

// File: tb/tb_sar_search_4bit.sv
// Directed bench for sar_search_4bit with a behavioural comparator and a flag override.
module tb_sar_search_4bit;

   logic       clk, rst, start;
   logic       AeqB, AgtB, AltB;
   logic [3:0] probe, result;
   logic       busy, done, found, err;

   logic [3:0] tbA;
   logic       ovr;
   logic [2:0] ovrFlags;
   logic [3:0] seq [0:15];
   int         checks, fails;

   sar_search_4bit #(.W(4)) dut (
      .clk(clk), .rst(rst), .start(start),
      .AeqB(AeqB), .AgtB(AgtB), .AltB(AltB),
      .probe(probe), .busy(busy), .done(done),
      .result(result), .found(found), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign {AeqB, AgtB, AltB} = ovr ? ovrFlags : {probe == tbA, tbA > probe, tbA < probe};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulses start, records each PROBE-cycle probe, returns in the done cycle.
   task automatic runSearch(input int chgAfter, input logic [3:0] newA, input int startAt,
                            output int n, output bit timedOut);
      bit changed;
      n = 0; timedOut = 1'b0; changed = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (done) return;
         if (busy) begin
            if (n < 16) seq[n] = probe;
            n++;
         end
         start = (n == startAt);
         tick();
         start = 1'b0;
         if (!changed && n == chgAfter) begin
            tbA = newA;
            changed = 1'b1;
         end
      end
      timedOut = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; tbA = 4'd0; ovr = 1'b0; ovrFlags = 3'b000;
      tick(); tick();
      rst = 1'b0;
      checks++;
      if ({probe, busy, done, result, found, err} !== 12'h000) begin
         fails++;
         $display("FAIL reset: probe=%0d busy=%b done=%b result=%0d found=%b err=%b, want all 0",
                  probe, busy, done, result, found, err);
      end
   endtask

   task automatic test_search(input logic [3:0] a, input logic [3:0] exp [], input bit expFound);
      int n; bit to;
      tbA = a;
      runSearch(-1, 4'd0, -1, n, to);
      checks++;
      if (to || n !== exp.size()) begin
         fails++; $display("FAIL search%0d_len: compares=%0d timeout=%b, want %0d", a, n, to, exp.size());
      end
      for (int i = 0; i < exp.size() && i < n; i++) begin
         checks++;
         if (seq[i] !== exp[i]) begin
            fails++; $display("FAIL search%0d_probe%0d: got %0d, want %0d", a, i, seq[i], exp[i]);
         end
      end
      checks++;
      if (done !== 1'b1 || result !== a || found !== expFound || busy !== 1'b0) begin
         fails++;
         $display("FAIL search%0d_out: done=%b result=%0d found=%b busy=%b, want 1 %0d %b 0",
                  a, done, result, found, busy, a, expFound);
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
         fails++; $display("FAIL search%0d_donepulse: done=%b one cycle later, want 0", a, done);
      end
   endtask

   task automatic test_moving_target();
      int n; bit to;
      // 9 -> 8 after the first compare: still inside [8,15], so it is located.
      tbA = 4'd9;
      runSearch(1, 4'd8, -1, n, to);
      checks++;
      if (to || n !== 4 || seq[1] !== 4'd11 || seq[2] !== 4'd9 || seq[3] !== 4'd8 ||
          result !== 4'd8 || found !== 1'b1) begin
         fails++; $display("FAIL move98: n=%0d to=%b seq=%0d,%0d,%0d result=%0d found=%b, want 4 0 11,9,8 8 1",
                           n, to, seq[1], seq[2], seq[3], result, found);
      end
      tick();
      // 9 -> 7 after the first compare: below lo=8, interval exhausts at 8.
      tbA = 4'd9;
      runSearch(1, 4'd7, -1, n, to);
      checks++;
      if (to || n !== 4 || seq[3] !== 4'd8 || result !== 4'd8 || found !== 1'b0) begin
         fails++; $display("FAIL exhaust: n=%0d to=%b last=%0d result=%0d found=%b, want 4 0 8 8 0",
                           n, to, seq[3], result, found);
      end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         fails++; $display("FAIL exhaust_idle: done=%b busy=%b, want 0 0", done, busy);
      end
   endtask

   task automatic test_start_ignored();
      int n; bit to;
      tbA = 4'd15;
      runSearch(-1, 4'd0, 2, n, to);
      checks++;
      if (to || n !== 5 || seq[2] !== 4'd13 || seq[3] !== 4'd14 || result !== 4'd15 || found !== 1'b1) begin
         fails++; $display("FAIL busy_start: n=%0d to=%b p2=%0d p3=%0d result=%0d found=%b, want 5 0 13 14 15 1",
                           n, to, seq[2], seq[3], result, found);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int n; bit to;
      tbA = 4'd7;
      runSearch(-1, 4'd0, -1, n, to);
      start = 1'b1; tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         fails++; $display("FAIL b2b_ignored: busy=%b done=%b after start in DONE, want 0 0", busy, done);
      end
      tick(); start = 1'b0;
      checks++;
      if (busy !== 1'b1 || probe !== 4'd7) begin
         fails++; $display("FAIL b2b_accept: busy=%b probe=%0d, want 1 7", busy, probe);
      end
      tick();
      checks++;
      if (done !== 1'b1 || result !== 4'd7 || found !== 1'b1) begin
         fails++; $display("FAIL b2b_result: done=%b result=%0d found=%b, want 1 7 1", done, result, found);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      bit sawDone;
      tbA = 4'd15;
      start = 1'b1; tick(); start = 1'b0;
      tick(); tick();
      checks++;
      if (busy !== 1'b1 || probe !== 4'd13) begin
         fails++; $display("FAIL rstmid_pre: busy=%b probe=%0d, want 1 13", busy, probe);
      end
      rst = 1'b1; tick(); rst = 1'b0;
      checks++;
      if ({probe, busy, done, result, found, err} !== 12'h000) begin
         fails++; $display("FAIL rstmid: probe=%0d busy=%b done=%b result=%0d found=%b err=%b, want all 0",
                           probe, busy, done, result, found, err);
      end
      sawDone = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (done || busy) sawDone = 1'b1;
         tick();
      end
      checks++;
      if (sawDone) begin
         fails++; $display("FAIL rstmid_quiet: activity=%b after abort, want 0", sawDone);
      end
   endtask

   task automatic test_err();
      tbA = 4'd11;
      start = 1'b1; tick(); start = 1'b0;
      ovr = 1'b1; ovrFlags = 3'b011;
      tick();
      ovr = 1'b0;
`ifdef SAR_SEARCH_ERR_EN
      checks++;
      if (done !== 1'b1 || err !== 1'b1 || found !== 1'b0 || result !== 4'd7) begin
         fails++; $display("FAIL err_abort: done=%b err=%b found=%b result=%0d, want 1 1 0 7",
                           done, err, found, result);
      end
      tick();
      checks++;
      if (err !== 1'b1 || done !== 1'b0) begin
         fails++; $display("FAIL err_hold: err=%b done=%b, want 1 0", err, done);
      end
`else
      checks++;
      if (busy !== 1'b1 || probe !== 4'd11 || err !== 1'b0) begin
         fails++; $display("FAIL err_decode: busy=%b probe=%0d err=%b, want 1 11 0", busy, probe, err);
      end
      tick();
      checks++;
      if (done !== 1'b1 || result !== 4'd11 || found !== 1'b1 || err !== 1'b0) begin
         fails++; $display("FAIL err_decode_end: done=%b result=%0d found=%b err=%b, want 1 11 1 0",
                           done, result, found, err);
      end
      tick();
      // All-zero flags narrow downwards: 7 -> 3.
      tbA = 4'd3;
      start = 1'b1; tick(); start = 1'b0;
      ovr = 1'b1; ovrFlags = 3'b000;
      tick();
      ovr = 1'b0;
      checks++;
      if (busy !== 1'b1 || probe !== 4'd3) begin
         fails++; $display("FAIL zero_flags: busy=%b probe=%0d, want 1 3", busy, probe);
      end
      tick();
      checks++;
      if (done !== 1'b1 || result !== 4'd3 || found !== 1'b1) begin
         fails++; $display("FAIL zero_flags_end: done=%b result=%0d found=%b, want 1 3 1", done, result, found);
      end
`endif
      tick();
   endtask

   initial begin
      logic [3:0] e7 [];
      logic [3:0] e15 [];
      logic [3:0] e0 [];
      checks = 0; fails = 0;
      e7  = '{4'd7};
      e15 = '{4'd7, 4'd11, 4'd13, 4'd14, 4'd15};
      e0  = '{4'd7, 4'd3, 4'd1, 4'd0};
      test_reset();
      test_search(4'd7, e7, 1'b1);
      test_search(4'd15, e15, 1'b1);
      test_search(4'd0, e0, 1'b1);
      test_moving_target();
      test_start_ignored();
      test_back_to_back();
      test_reset_mid();
      test_search(4'd15, e15, 1'b1);
      test_err();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
